// File: rtl/timer_sched.sv
// timer_sched: round-robin timeout scheduler sharing one 32-bit comparator against an external free-running timer.
// Define TIMER_SCHED_PERIODIC_EN to add auto-rearming periodic channels (adds input i_wr_periodic).
module timer_sched #(
  parameter int NCH = 4
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic           i_run,
  input  logic           i_wr,
  input  logic [2:0]     i_wr_ch,
  input  logic [31:0]    i_wr_delay,
`ifdef TIMER_SCHED_PERIODIC_EN
  input  logic           i_wr_periodic,
`endif
  input  logic [NCH-1:0] i_ack,
  input  logic [31:0]    i_tmr_value,
  input  logic           i_tmr_overflow,
  output logic           o_tmr_enable,
  output logic           o_tmr_clearw,
  output logic           o_tmr_showtime,
  output logic [NCH-1:0] o_busy,
  output logic [NCH-1:0] o_expired,
  output logic           o_irq
);
  localparam int IW = $clog2(NCH);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state;
  logic [31:0] deadline [NCH];
  logic [NCH-1:0] wrap_pending, expire;
  logic [IW-1:0] ptr, sel, wr_idx;
  logic [32:0] wr_sum;
  logic ovf_ign, ovf, scan_en, hit, wr_ok;
  logic unused_wr_ch;
  function automatic logic [IW-1:0] rr(input logic [IW-1:0] p, input int k);
    int t;
    t = (int'(p) + k) % NCH;
    return t[IW-1:0];
  endfunction
  // First busy channel at or after the pointer, so idle channels cost no cycle.
  always_comb begin
    sel = ptr;
    for (int k = NCH - 1; k >= 0; k--)
      if (o_busy[rr(ptr, k)]) sel = rr(ptr, k);
  end
  assign wr_idx = i_wr_ch[IW-1:0];
  assign unused_wr_ch = ^i_wr_ch;
  assign wr_ok = i_wr && int'(wr_idx) < NCH;
  assign wr_sum = {1'b0, i_tmr_value} + {1'b0, i_wr_delay};
  // The sticky flag is still visible during the clear pulse and the cycle after it.
  assign ovf = i_tmr_overflow && !o_tmr_clearw && !ovf_ign;
  assign scan_en = state == SCAN && i_run && |o_busy;
  assign hit = scan_en && !wrap_pending[sel] && i_tmr_value >= deadline[sel];
  assign expire = ovf ? o_busy & ~wrap_pending : (hit ? NCH'(1) << sel : '0);
  assign o_irq = |o_expired;
  assign o_tmr_showtime = !i_reset;
`ifdef TIMER_SCHED_PERIODIC_EN
  logic [31:0] period [NCH];
  logic [NCH-1:0] periodic;
  logic [32:0] re_sum [NCH];
  always_comb
    for (int i = 0; i < NCH; i++) re_sum[i] = {1'b0, deadline[i]} + {1'b0, period[i]};
`endif
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      ptr <= '0;
      o_busy <= '0;
      o_expired <= '0;
      wrap_pending <= '0;
      o_tmr_enable <= 1'b0;
      o_tmr_clearw <= 1'b0;
      ovf_ign <= 1'b0;
      for (int i = 0; i < NCH; i++) deadline[i] <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
      periodic <= '0;
      for (int i = 0; i < NCH; i++) period[i] <= '0;
`endif
    end else begin
      o_tmr_enable <= i_run;
      o_tmr_clearw <= ovf;
      ovf_ign <= o_tmr_clearw;
      state <= |o_busy ? SCAN : IDLE;
      if (scan_en) ptr <= rr(sel, 1);
      if (ovf) wrap_pending <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (expire[i]) begin
          o_expired[i] <= 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
          if (periodic[i]) begin
            deadline[i] <= re_sum[i][31:0];
            wrap_pending[i] <= re_sum[i][32] && !ovf;
          end else
            o_busy[i] <= 1'b0;
`else
          o_busy[i] <= 1'b0;
`endif
        end else if (i_ack[i])
          o_expired[i] <= 1'b0;
        if (wr_ok && wr_idx == IW'(i)) begin
          deadline[i] <= wr_sum[31:0];
          wrap_pending[i] <= wr_sum[32];
          o_busy[i] <= 1'b1;
          o_expired[i] <= 1'b0;
`ifdef TIMER_SCHED_PERIODIC_EN
          period[i] <= i_wr_delay;
          periodic[i] <= i_wr_periodic;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: scoreboard bench for timer_sched driving a behavioural shared 32-bit timer.
module tb_timer_sched;
  localparam int NCH = 4;
  logic i_clock = 1'b0, i_reset = 1'b1, i_run = 1'b0, i_wr = 1'b0;
  logic [2:0] i_wr_ch = '0;
  logic [31:0] i_wr_delay = '0;
  logic i_wr_periodic = 1'b0;
  logic [NCH-1:0] i_ack = '0;
  logic [31:0] tmr = '0, ld_val = '0;
  logic ovf = 1'b0, ld = 1'b0, ld_ovf = 1'b0;
  logic o_tmr_enable, o_tmr_clearw, o_tmr_showtime, o_irq;
  logic [NCH-1:0] o_busy, o_expired;
  int checks = 0, failures = 0;
  typedef struct { int ch; logic [31:0] lo; logic [31:0] hi; } exp_t;
  exp_t sb[$];

  timer_sched #(.NCH(NCH)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_run(i_run), .i_wr(i_wr),
    .i_wr_ch(i_wr_ch), .i_wr_delay(i_wr_delay),
`ifdef TIMER_SCHED_PERIODIC_EN
    .i_wr_periodic(i_wr_periodic),
`endif
    .i_ack(i_ack), .i_tmr_value(tmr), .i_tmr_overflow(ovf),
    .o_tmr_enable(o_tmr_enable), .o_tmr_clearw(o_tmr_clearw), .o_tmr_showtime(o_tmr_showtime),
    .o_busy(o_busy), .o_expired(o_expired), .o_irq(o_irq)
  );

  always #5 i_clock = ~i_clock;

  // Shared timer: counts when enabled, sticky overflow on wrap, cleared by clearw or reset.
  always @(posedge i_clock) begin
    if (ld) begin
      tmr <= ld_val;
      ovf <= ld_ovf;
    end else begin
      if (o_tmr_enable) tmr <= tmr + 32'd1;
      if (i_reset || o_tmr_clearw) ovf <= 1'b0;
      else if (o_tmr_enable && tmr == '1) ovf <= 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  task automatic push_exp(input int ch, input logic [31:0] lo, input logic [31:0] hi);
    exp_t e;
    int i;
    e.ch = ch; e.lo = lo; e.hi = hi;
    i = 0;
    while (i < sb.size() && sb[i].lo <= lo) i++;
    sb.insert(i, e);
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_wr = 1'b0; i_ack = '0; i_run = 1'b1;
    sb.delete();
    cyc(2);
    i_reset = 1'b0;
    cyc(1);
  endtask

  task automatic load_tmr(input logic [31:0] v, input logic o);
    ld = 1'b1; ld_val = v; ld_ovf = o;
    cyc(1);
    ld = 1'b0;
  endtask

  task automatic write_ch(input int ch, input logic [31:0] d, input logic per);
    i_wr = 1'b1; i_wr_ch = 3'(ch); i_wr_delay = d; i_wr_periodic = per;
    cyc(1);
    i_wr = 1'b0;
  endtask

  // Observes only: waits for a rising o_expired bit, counting clearw cycles meanwhile.
  task automatic wait_rise(input int bound, output int ch, output logic [31:0] t, output bit ok, output int clr_n);
    logic [NCH-1:0] prev, rise;
    ok = 1'b0; ch = -1; t = '0; clr_n = 0;
    prev = o_expired;
    for (int k = 0; k < bound && !ok; k++) begin
      cyc(1);
      clr_n += int'(o_tmr_clearw);
      rise = o_expired & ~prev;
      prev = o_expired;
      for (int c = NCH - 1; c >= 0; c--)
        if (rise[c]) begin ok = 1'b1; ch = c; t = tmr; end
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_run = 1'b1;
    cyc(2);
    checks++;
    if (o_busy !== '0 || o_expired !== '0 || o_irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: busy=%b expired=%b irq=%b, want all 0", o_busy, o_expired, o_irq);
    end
    checks++;
    if ({o_tmr_enable, o_tmr_clearw, o_tmr_showtime} !== 3'b000) begin
      failures++;
      $display("FAIL reset_tmr: en/clr/show=%b, want 000", {o_tmr_enable, o_tmr_clearw, o_tmr_showtime});
    end
    i_reset = 1'b0;
    cyc(1);
    checks++;
    if ({o_tmr_enable, o_tmr_showtime, o_tmr_clearw} !== 3'b110) begin
      failures++;
      $display("FAIL post_reset: en/show/clr=%b, want 110", {o_tmr_enable, o_tmr_showtime, o_tmr_clearw});
    end
  endtask

  task automatic test_basic();
    int ch, cn;
    logic [31:0] t;
    bit ok;
    exp_t e;
    do_reset();
    load_tmr(32'd100, 1'b0);
    push_exp(1, 32'd151, 32'd150 + NCH + 1);
    write_ch(1, 32'd50, 1'b0);
    checks++;
    if (o_busy !== 4'b0010) begin failures++; $display("FAIL basic_busy: busy=%b, want 0010", o_busy); end
    wait_rise(200, ch, t, ok, cn);
    e = sb.pop_front();
    checks++;
    if (!ok || ch != e.ch || t < e.lo || t > e.hi) begin
      failures++;
      $display("FAIL basic_expiry: seen=%0d ch=%0d tmr=%0d, want ch=%0d tmr in [%0d,%0d]", ok, ch, t, e.ch, e.lo, e.hi);
    end
    checks++;
    if (o_irq !== 1'b1 || o_busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL basic_irq: irq=%b busy=%b, want irq 1 busy[1] 0", o_irq, o_busy);
    end
    i_ack = 4'b0010;
    cyc(1);
    i_ack = '0;
    checks++;
    if (o_expired !== '0 || o_irq !== 1'b0) begin
      failures++;
      $display("FAIL basic_ack: expired=%b irq=%b, want 0", o_expired, o_irq);
    end
  endtask

  task automatic test_wrap();
    int ch, cn;
    logic [31:0] t;
    bit ok;
    exp_t e;
    do_reset();
    load_tmr(32'hFFFF_FFF0, 1'b0);
    push_exp(0, 32'h11, 32'h10 + NCH + 1);
    write_ch(0, 32'h20, 1'b0);
    wait_rise(100, ch, t, ok, cn);
    e = sb.pop_front();
    checks++;
    if (!ok || ch != e.ch || t < e.lo || t > e.hi) begin
      failures++;
      $display("FAIL wrap_expiry: seen=%0d ch=%0d tmr=%0h, want ch=%0d tmr in [%0h,%0h]", ok, ch, t, e.ch, e.lo, e.hi);
    end
    checks++;
    if (cn != 1) begin failures++; $display("FAIL wrap_clearw: clearw high %0d cycles before expiry, want 1", cn); end
  endtask

  task automatic test_edge();
    int ch, cn;
    logic [31:0] t;
    bit ok;
    exp_t e;
    do_reset();
    load_tmr(32'hFFFF_FF00, 1'b0);
    write_ch(0, 32'h1000, 1'b0);
    write_ch(1, 32'h2000, 1'b0);
    write_ch(2, 32'hFFFF_FFFF - tmr, 1'b0);
    cyc(5);
    load_tmr(32'h5, 1'b1);
    push_exp(2, 32'h6, 32'h6);
    wait_rise(3, ch, t, ok, cn);
    e = sb.pop_front();
    checks++;
    if (!ok || ch != e.ch || t < e.lo || t > e.hi) begin
      failures++;
      $display("FAIL edge_expiry: seen=%0d ch=%0d tmr=%0h, want ch=%0d tmr=%0h", ok, ch, t, e.ch, e.lo);
    end
    checks++;
    if (o_tmr_clearw !== 1'b1 || o_expired[1:0] !== 2'b00) begin
      failures++;
      $display("FAIL edge_ovf: clearw=%b expired=%b, want clearw 1, ch0/ch1 not expired", o_tmr_clearw, o_expired);
    end
    cyc(1);
    checks++;
    if (o_tmr_clearw !== 1'b0) begin failures++; $display("FAIL edge_pulse: clearw=%b one cycle later, want 0", o_tmr_clearw); end
  endtask

  task automatic test_ack_collide();
    int ch, cn;
    logic [31:0] t;
    bit ok;
    exp_t e;
    do_reset();
    i_ack = 4'b0010;
    push_exp(1, tmr + 1, tmr + NCH + 1);
    write_ch(1, 32'd0, 1'b0);
    wait_rise(20, ch, t, ok, cn);
    e = sb.pop_front();
    checks++;
    if (!ok || ch != e.ch || t < e.lo || t > e.hi) begin
      failures++;
      $display("FAIL ack_set_wins: seen=%0d ch=%0d tmr=%0d, want ch=%0d tmr in [%0d,%0d]", ok, ch, t, e.ch, e.lo, e.hi);
    end
    cyc(1);
    checks++;
    if (o_expired[1] !== 1'b0) begin failures++; $display("FAIL ack_clear: expired[1]=%b, want 0", o_expired[1]); end
    i_ack = '0;
    push_exp(1, tmr + 1, tmr + NCH + 1);
    write_ch(1, 32'd0, 1'b0);
    wait_rise(20, ch, t, ok, cn);
    e = sb.pop_front();
    checks++;
    if (!ok || ch != e.ch || t < e.lo || t > e.hi) begin
      failures++;
      $display("FAIL zero_delay: seen=%0d ch=%0d tmr=%0d, want ch=%0d tmr in [%0d,%0d]", ok, ch, t, e.ch, e.lo, e.hi);
    end
    i_wr = 1'b1; i_wr_ch = 3'd1; i_wr_delay = 32'd1000; i_ack = 4'b0010;
    cyc(1);
    i_wr = 1'b0; i_ack = '0;
    checks++;
    if (o_busy[1] !== 1'b1 || o_expired[1] !== 1'b0) begin
      failures++;
      $display("FAIL wr_over_ack: busy[1]=%b expired[1]=%b, want 1/0", o_busy[1], o_expired[1]);
    end
  endtask

  task automatic test_back_to_back();
    int ch, cn;
    logic [31:0] t;
    bit ok;
    exp_t e;
    int dly[4] = '{40, 10, 30, 20};
    do_reset();
    load_tmr(32'd1000, 1'b0);
    for (int c = 0; c < NCH; c++) begin
      push_exp(c, tmr + dly[c] + 1, tmr + dly[c] + NCH + 1);
      write_ch(c, dly[c], 1'b0);
    end
    checks++;
    if (o_busy !== 4'b1111) begin failures++; $display("FAIL b2b_busy: busy=%b, want 1111", o_busy); end
    for (int n = 0; n < NCH; n++) begin
      wait_rise(100, ch, t, ok, cn);
      e = sb.pop_front();
      checks++;
      if (!ok || ch != e.ch || t < e.lo || t > e.hi) begin
        failures++;
        $display("FAIL b2b_expiry%0d: seen=%0d ch=%0d tmr=%0d, want ch=%0d tmr in [%0d,%0d]", n, ok, ch, t, e.ch, e.lo, e.hi);
      end
      if (ok) begin
        i_ack = '0;
        i_ack[ch] = 1'b1;
        cyc(1);
        i_ack = '0;
      end
    end
    checks++;
    if (o_busy !== '0 || o_irq !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done: busy=%b irq=%b, want 0", o_busy, o_irq);
    end
  endtask

  task automatic test_pause();
    int ch, cn;
    logic [31:0] t, dl;
    bit ok;
    exp_t e;
    do_reset();
    load_tmr(32'd500, 1'b0);
    dl = tmr + 32'd20;
    write_ch(0, 32'd20, 1'b0);
    i_run = 1'b0;
    cyc(2);
    load_tmr(dl + 32'd50, 1'b0);
    wait_rise(20, ch, t, ok, cn);
    checks++;
    if (ok || o_busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL pause_hold: expired_seen=%0d busy[0]=%b, want 0/1", ok, o_busy[0]);
    end
    push_exp(0, dl + 32'd50, dl + 32'd50 + NCH + 1);
    i_run = 1'b1;
    wait_rise(20, ch, t, ok, cn);
    e = sb.pop_front();
    checks++;
    if (!ok || ch != e.ch || t < e.lo || t > e.hi) begin
      failures++;
      $display("FAIL pause_resume: seen=%0d ch=%0d tmr=%0d, want ch=%0d tmr in [%0d,%0d]", ok, ch, t, e.ch, e.lo, e.hi);
    end
  endtask

  task automatic test_reset_mid();
    int ch, cn;
    logic [31:0] t;
    bit ok;
    do_reset();
    load_tmr(32'd1000, 1'b0);
    write_ch(0, 32'd50, 1'b0);
    write_ch(1, 32'd60, 1'b0);
    write_ch(2, 32'd70, 1'b0);
    cyc(3);
    i_reset = 1'b1;
    cyc(1);
    checks++;
    if ({o_busy, o_expired, o_irq, o_tmr_enable, o_tmr_clearw} !== '0) begin
      failures++;
      $display("FAIL midreset_out: busy=%b expired=%b irq=%b en=%b clr=%b, want all 0",
               o_busy, o_expired, o_irq, o_tmr_enable, o_tmr_clearw);
    end
    i_reset = 1'b0;
    wait_rise(150, ch, t, ok, cn);
    checks++;
    if (ok || cn != 0 || o_busy !== '0) begin
      failures++;
      $display("FAIL midreset_after: expiry_seen=%0d clearw_cycles=%0d busy=%b, want 0/0/0", ok, cn, o_busy);
    end
  endtask

`ifdef TIMER_SCHED_PERIODIC_EN
  task automatic test_periodic();
    int ch, cn;
    logic [31:0] t, base;
    bit ok;
    exp_t e;
    do_reset();
    load_tmr(32'd2000, 1'b0);
    base = tmr;
    for (int n = 1; n <= 3; n++) push_exp(3, base + 10 * n + 1, base + 10 * n + NCH + 1);
    write_ch(3, 32'd10, 1'b1);
    for (int n = 0; n < 3; n++) begin
      wait_rise(40, ch, t, ok, cn);
      e = sb.pop_front();
      checks++;
      if (!ok || ch != e.ch || t < e.lo || t > e.hi) begin
        failures++;
        $display("FAIL periodic%0d: seen=%0d ch=%0d tmr=%0d, want ch=%0d tmr in [%0d,%0d]", n, ok, ch, t, e.ch, e.lo, e.hi);
      end
      checks++;
      if (o_busy[3] !== 1'b1) begin failures++; $display("FAIL periodic_busy%0d: busy[3]=%b, want 1", n, o_busy[3]); end
      i_ack = 4'b1000;
      cyc(1);
      i_ack = '0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_edge();
    test_ack_collide();
    test_back_to_back();
    test_pause();
    test_reset_mid();
`ifdef TIMER_SCHED_PERIODIC_EN
    test_periodic();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
